// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and helpers for the instruction-fetch front end.
// Also serves as the common parameter set used by the rest of the fetch slice.
package fetch_unit_pkg;

    localparam int unsigned FETCH_ADDR     = 32;
    localparam int unsigned FETCH_W_INSTR  = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: branch redirect, instruction-memory port and decode handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR    = FETCH_ADDR,
    parameter int unsigned W_INSTR = FETCH_W_INSTR
);
    logic               branch_i;
    logic [ADDR-1:0]    branch_addr_i;
    logic               imem_req_o;
    logic [ADDR-1:0]    imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_ack_i;
    logic [W_INSTR-1:0] imem_data_i;
    logic               v_o;
    logic [W_INSTR-1:0] instr_o;
    logic [ADDR-1:0]    pc_o;
    logic               ready_i;

    modport master (
        input  branch_i, branch_addr_i, imem_gnt_i, imem_ack_i, imem_data_i, ready_i,
        output imem_req_o, imem_addr_o, v_o, instr_o, pc_o
    );

    modport slave (
        output branch_i, branch_addr_i, imem_gnt_i, imem_ack_i, imem_data_i, ready_i,
        input  imem_req_o, imem_addr_o, v_o, instr_o, pc_o
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, instr} pairs; push and pop may coincide even when full.
// Head is read straight from registered storage, so there is no path from i_data to o_data.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one-outstanding imem reads, branch flush/drop, output queue.
// Optional FETCH_STATS_EN adds saturating flush/drop counters (flush_cnt_o, drop_cnt_o).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     ADDR     = FETCH_ADDR,
    parameter int unsigned     W_INSTR  = FETCH_W_INSTR,
    parameter int unsigned     QDEPTH   = 4,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [ADDR-1:0] RESET_PC = ADDR'(FETCH_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  flush_cnt_o,
    output logic [31:0]  drop_cnt_o
`endif
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e            r_state;
    fetch_state_e            w_state_next;
    logic [ADDR-1:0]         r_pc;
    logic [ADDR-1:0]         r_tag_pc;
    logic                    r_boot;
    logic                    w_fire;
    logic                    w_push;
    logic                    w_pop;
    logic [CW-1:0]           w_count;
    logic                    w_empty;
    logic                    w_full;
    logic [ADDR+W_INSTR-1:0] w_head;

    assign w_fire = bus.imem_req_o & bus.imem_gnt_i;
    assign w_pop  = ~w_empty & bus.ready_i;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_REQ;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_REQ:  if (w_fire) w_state_next = bus.branch_i ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (bus.imem_ack_i)    w_state_next = S_REQ;
                else if (bus.branch_i) w_state_next = S_DROP;
            end
            S_DROP: if (bus.imem_ack_i) w_state_next = S_REQ;
            default: w_state_next = S_REQ;
        endcase
    end

    // The memory leaves reset together with us; give it one idle cycle before the first request.
    always_comb begin
        bus.imem_req_o = 1'b0;
        w_push         = 1'b0;
        unique case (r_state)
            S_REQ:   bus.imem_req_o = ~r_boot & (w_count < CW'(QDEPTH));
            S_WAIT:  w_push = bus.imem_ack_i & ~bus.branch_i & (~w_full | w_pop);
            S_DROP:  w_push = 1'b0;
            default: w_push = 1'b0;
        endcase
    end

    assign bus.imem_addr_o = r_pc;

    always_ff @(posedge clk) begin
        if (rst) r_boot <= 1'b1;
        else     r_boot <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)               r_pc <= RESET_PC;
        else if (bus.branch_i) r_pc <= bus.branch_addr_i;
        else if (w_fire)       r_pc <= r_pc + ADDR'(PC_STEP);
    end

    always_ff @(posedge clk) begin
        if (w_fire) r_tag_pc <= r_pc;
    end

    fetch_queue #(
        .WIDTH (ADDR + W_INSTR),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_tag_pc, bus.imem_data_i}),
        .i_pop   (w_pop),
        .i_flush (bus.branch_i),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign bus.v_o     = ~w_empty;
    assign bus.pc_o    = w_head[ADDR+W_INSTR-1:W_INSTR];
    assign bus.instr_o = w_head[W_INSTR-1:0];

`ifdef FETCH_STATS_EN
    logic [31:0] r_flush_cnt;
    logic [31:0] r_drop_cnt;
    logic        w_drop_ack;

    // An ack is discarded when it lands in DROP, or in WAIT together with a branch.
    assign w_drop_ack = bus.imem_ack_i &
                        ((r_state == S_DROP) | ((r_state == S_WAIT) & bus.branch_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (bus.branch_i) r_flush_cnt <= sat_inc32(r_flush_cnt);
            if (w_drop_ack)   r_drop_cnt  <= sat_inc32(r_drop_cnt);
        end
    end

    assign flush_cnt_o = r_flush_cnt;
    assign drop_cnt_o  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFFFFFC) and a simple
// one-outstanding memory responder; stats checks only when FETCH_STATS_EN is defined.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if m0 ();
    fetch_unit_if m1 ();

`ifdef FETCH_STATS_EN
    logic [31:0] flush0, drop0, flush1, drop1;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (m0.master)
`ifdef FETCH_STATS_EN
        ,
        .flush_cnt_o (flush0),
        .drop_cnt_o  (drop0)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (m1.master)
`ifdef FETCH_STATS_EN
        ,
        .flush_cnt_o (flush1),
        .drop_cnt_o  (drop1)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    bit          pend [2];
    int          pend_cnt [2];
    logic [31:0] pend_addr [2];
    int          n_gnt [2];
    bit          gnt_en = 1'b1;
    int          ack_lat = 1;

    // Memory model: grant whenever requested, ack ack_lat cycles later with data = ~addr.
    task automatic resp(input int k, input logic req, input logic [31:0] addr,
                        output logic gnt, output logic ack, output logic [31:0] data);
        gnt  = 1'b0;
        ack  = 1'b0;
        data = 32'h0;
        if (pend[k]) begin
            if (pend_cnt[k] <= 1) begin
                ack     = 1'b1;
                data    = ~pend_addr[k];
                pend[k] = 1'b0;
            end else begin
                pend_cnt[k] = pend_cnt[k] - 1;
            end
        end else if (gnt_en && req === 1'b1) begin
            gnt          = 1'b1;
            pend[k]      = 1'b1;
            pend_cnt[k]  = ack_lat;
            pend_addr[k] = addr;
            n_gnt[k]     = n_gnt[k] + 1;
        end
    endtask

    task automatic step();
        logic g, a;
        logic [31:0] d;
        resp(0, m0.imem_req_o, m0.imem_addr_o, g, a, d);
        m0.imem_gnt_i = g; m0.imem_ack_i = a; m0.imem_data_i = d;
        resp(1, m1.imem_req_o, m1.imem_addr_o, g, a, d);
        m1.imem_gnt_i = g; m1.imem_ack_i = a; m1.imem_data_i = d;
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        m0.branch_i = 1'b0; m0.branch_addr_i = 32'h0; m0.imem_gnt_i = 1'b0;
        m0.imem_ack_i = 1'b0; m0.imem_data_i = 32'h0; m0.ready_i = 1'b1;
        m1.branch_i = 1'b0; m1.branch_addr_i = 32'h0; m1.imem_gnt_i = 1'b0;
        m1.imem_ack_i = 1'b0; m1.imem_data_i = 32'h0; m1.ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; pend_cnt[k] = 0; pend_addr[k] = 32'h0; n_gnt[k] = 0;
        end
        gnt_en = 1'b1;
        ack_lat = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_valid0(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (m0.v_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        n_cmp++; if (m0.v_o !== 1'b0) begin n_err++; $display("FAIL rst_v0: got %b want 0", m0.v_o); end
        n_cmp++; if (m0.imem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req0: got %b want 0", m0.imem_req_o); end
        n_cmp++; if (m1.imem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req1: got %b want 0", m1.imem_req_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (m0.imem_req_o !== 1'b1) begin n_err++; $display("FAIL rst_req0_on: got %b want 1", m0.imem_req_o); end
        n_cmp++; if (m0.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr0: got %h want 00000000", m0.imem_addr_o); end
        n_cmp++; if (m1.imem_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL rst_addr1: got %h want fffffffc", m1.imem_addr_o); end
        n_cmp++; if (m0.v_o !== 1'b0) begin n_err++; $display("FAIL rst_v0_idle: got %b want 0", m0.v_o); end
    endtask

    task automatic test_sequential();
        int got;
        bit seen_ack;
        logic [31:0] exp_pc;
        do_reset();
        got = 0;
        seen_ack = 1'b0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            step();
            if (!seen_ack) begin
                n_cmp++;
                if (m0.imem_ack_i === 1'b1) begin
                    seen_ack = 1'b1;
                    if (m0.v_o !== 1'b1) begin n_err++; $display("FAIL seq_first_valid: got %b want 1", m0.v_o); end
                end else if (m0.v_o !== 1'b0) begin
                    n_err++; $display("FAIL seq_early_valid: got %b want 0", m0.v_o);
                end
            end
            if (m0.v_o === 1'b1) begin
                exp_pc = 32'(got * 4);
                n_cmp++;
                if (m0.pc_o !== exp_pc || m0.instr_o !== ~exp_pc) begin
                    n_err++;
                    $display("FAIL seq_pc%0d: got pc %h instr %h want pc %h instr %h",
                             got, m0.pc_o, m0.instr_o, exp_pc, ~exp_pc);
                end
                got++;
            end
        end
        n_cmp++; if (got != 4) begin n_err++; $display("FAIL seq_count: got %0d want 4", got); end
    endtask

    task automatic test_backpressure();
        do_reset();
        m0.ready_i = 1'b0;
        repeat (30) step();
        n_cmp++; if (n_gnt[0] != 4) begin n_err++; $display("FAIL bp_grants: got %0d want 4", n_gnt[0]); end
        n_cmp++; if (m0.imem_req_o !== 1'b0) begin n_err++; $display("FAIL bp_req_full: got %b want 0", m0.imem_req_o); end
        n_cmp++; if (m0.v_o !== 1'b1 || m0.pc_o !== 32'h0) begin n_err++; $display("FAIL bp_head: got v %b pc %h want v 1 pc 00000000", m0.v_o, m0.pc_o); end
        m0.ready_i = 1'b1;
        step();
        m0.ready_i = 1'b0;
        repeat (10) step();
        n_cmp++; if (n_gnt[0] != 5) begin n_err++; $display("FAIL bp_one_more: got %0d want 5", n_gnt[0]); end
        n_cmp++; if (m0.pc_o !== 32'h4) begin n_err++; $display("FAIL bp_head2: got %h want 00000004", m0.pc_o); end
    endtask

    // Drains the full queue left by test_backpressure while refills arrive.
    task automatic test_back_to_back();
        int got;
        logic [31:0] exp_pc;
        got = 0;
        m0.ready_i = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (m0.v_o === 1'b1) begin
                exp_pc = 32'(4 + got * 4);
                n_cmp++;
                if (m0.pc_o !== exp_pc || m0.instr_o !== ~exp_pc) begin
                    n_err++;
                    $display("FAIL b2b_pc%0d: got pc %h instr %h want pc %h", got, m0.pc_o, m0.instr_o, exp_pc);
                end
                got++;
            end
            step();
        end
        n_cmp++; if (got != 6) begin n_err++; $display("FAIL b2b_count: got %0d want 6", got); end
    endtask

    task automatic test_branch_wait();
        bit ok;
        do_reset();
        ack_lat = 4;
        step();
        m0.branch_i = 1'b1; m0.branch_addr_i = 32'h100;
        step();
        m0.branch_i = 1'b0;
        n_cmp++; if (m0.imem_req_o !== 1'b0) begin n_err++; $display("FAIL bw_req_drop: got %b want 0", m0.imem_req_o); end
        repeat (3) step();
        n_cmp++; if (m0.v_o !== 1'b0) begin n_err++; $display("FAIL bw_data_dropped: got v %b want 0", m0.v_o); end
        n_cmp++; if (m0.imem_req_o !== 1'b1 || m0.imem_addr_o !== 32'h100) begin
            n_err++; $display("FAIL bw_next_req: got req %b addr %h want req 1 addr 00000100", m0.imem_req_o, m0.imem_addr_o);
        end
        ack_lat = 1;
        wait_valid0(ok);
        n_cmp++; if (!ok || m0.pc_o !== 32'h100 || m0.instr_o !== ~32'h100) begin
            n_err++; $display("FAIL bw_first_pc: got ok %b pc %h instr %h want pc 00000100", ok, m0.pc_o, m0.instr_o);
        end
    endtask

    task automatic test_branch_ack();
        bit ok;
        do_reset();
        step();
        m0.branch_i = 1'b1; m0.branch_addr_i = 32'h200;
        step();
        m0.branch_i = 1'b0;
        n_cmp++; if (m0.v_o !== 1'b0) begin n_err++; $display("FAIL ba_queue_empty: got v %b want 0", m0.v_o); end
        n_cmp++; if (m0.imem_req_o !== 1'b1 || m0.imem_addr_o !== 32'h200) begin
            n_err++; $display("FAIL ba_no_drop: got req %b addr %h want req 1 addr 00000200", m0.imem_req_o, m0.imem_addr_o);
        end
        wait_valid0(ok);
        n_cmp++; if (!ok || m0.pc_o !== 32'h200) begin n_err++; $display("FAIL ba_first_pc: got ok %b pc %h want 00000200", ok, m0.pc_o); end
    endtask

    task automatic test_branch_req();
        bit ok;
        do_reset();
        m0.branch_i = 1'b1; m0.branch_addr_i = 32'h300;
        step();
        m0.branch_i = 1'b0;
        n_cmp++; if (m0.imem_req_o !== 1'b0) begin n_err++; $display("FAIL br_gnt_drop: got req %b want 0", m0.imem_req_o); end
        step();
        n_cmp++; if (m0.imem_req_o !== 1'b1 || m0.imem_addr_o !== 32'h300 || m0.v_o !== 1'b0) begin
            n_err++; $display("FAIL br_after_drop: got req %b addr %h v %b want 1 00000300 0", m0.imem_req_o, m0.imem_addr_o, m0.v_o);
        end
        // Partly fill the queue, then branch from REQ with no grant.
        m0.ready_i = 1'b0;
        repeat (6) step();
        n_cmp++; if (m0.v_o !== 1'b1 || m0.pc_o !== 32'h300) begin n_err++; $display("FAIL br_filled: got v %b pc %h want 1 00000300", m0.v_o, m0.pc_o); end
        gnt_en = 1'b0;
        m0.branch_i = 1'b1; m0.branch_addr_i = 32'h400;
        step();
        m0.branch_i = 1'b0;
        n_cmp++; if (m0.v_o !== 1'b0 || m0.imem_req_o !== 1'b1 || m0.imem_addr_o !== 32'h400) begin
            n_err++; $display("FAIL br_flush: got v %b req %b addr %h want 0 1 00000400", m0.v_o, m0.imem_req_o, m0.imem_addr_o);
        end
        gnt_en = 1'b1;
        m0.ready_i = 1'b1;
        wait_valid0(ok);
        n_cmp++; if (!ok || m0.pc_o !== 32'h400) begin n_err++; $display("FAIL br_first_pc: got ok %b pc %h want 00000400", ok, m0.pc_o); end
    endtask

    task automatic test_wrap();
        int got;
        logic [31:0] pcs [2];
        do_reset();
        got = 0;
        for (int c = 0; c < 30 && got < 2; c++) begin
            step();
            if (m1.v_o === 1'b1) begin
                pcs[got] = m1.pc_o;
                got++;
            end
        end
        n_cmp++; if (got != 2 || pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
            n_err++; $display("FAIL wrap_pc: got n %0d pcs %h %h want fffffffc 00000000", got, pcs[0], pcs[1]);
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        do_reset();
        n_cmp++; if (flush0 !== 32'd0 || drop0 !== 32'd0) begin n_err++; $display("FAIL st_reset0: got %0d %0d want 0 0", flush0, drop0); end
        gnt_en = 1'b0;
        m0.branch_addr_i = 32'h40;
        repeat (2) begin
            m0.branch_i = 1'b1; step();
            m0.branch_i = 1'b0; step();
        end
        gnt_en = 1'b1;
        ack_lat = 3;
        step();
        m0.branch_i = 1'b1; m0.branch_addr_i = 32'h80;
        step();
        m0.branch_i = 1'b0;
        repeat (4) step();
        n_cmp++; if (flush0 !== 32'd3) begin n_err++; $display("FAIL st_flush: got %0d want 3", flush0); end
        n_cmp++; if (drop0 !== 32'd1) begin n_err++; $display("FAIL st_drop: got %0d want 1", drop0); end
        do_reset();
        n_cmp++; if (flush0 !== 32'd0 || drop0 !== 32'd0) begin n_err++; $display("FAIL st_clear: got %0d %0d want 0 0", flush0, drop0); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_back_to_back();
        test_branch_wait();
        test_branch_ack();
        test_branch_req();
        test_wrap();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
